mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
Sequential shift-and-add multiply/accumulate controller. It replaces the single-edge combinational product on the board with a W-cycle sequenced multiply. It has a Start/Busy/Done handshake and an optional accumulate mode. It sits between the debounced key/switch inputs and the hex display decoders: it takes operands from SW and a debounced Start pulse, and drives a result register to the HEX digits.

Parameters:
W, 4, operand width in bits (A and B)
ACC_W, 16, result/accumulator width in bits (must be >= 2*W)

Ports:
Clock  input  1  system clock, rising-edge active
Resetn  input  1  asynchronous active-low reset
Start  input  1  request a multiply; sampled only in IDLE; level or pulse
Accum  input  1  sampled with Start; 1 = add product to Result, 0 = overwrite Result
Clear  input  1  synchronous clear of Result and Ovf; honoured only in IDLE
A  input  W  multiplicand, sampled with Start
B  input  W  multiplier, sampled with Start
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse; Result is valid and updated in that cycle
Result  output  ACC_W  product or accumulated sum, held between operations
Ovf  output  1  sticky; set when an accumulate carries out of ACC_W bits

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE, Result=0, Ovf=0, Busy=0, Done=0, internal regs=0. Reset mid-operation aborts with no Done.
- States: IDLE, RUN, FIN.
- IDLE:
  - Clear=1: Result<=0, Ovf<=0, stay IDLE. Clear has priority over Start, so a simultaneous Start is dropped.
  - Else Start=1: capture ma<=zero-extended A (2W bits), mb<=B, acc_mode<=Accum, prod<=0, cnt<=0; go RUN.
- RUN, one step per cycle:
  - If mb[0], prod<=prod+ma.
  - ma<=ma<<1; mb<=mb>>1; cnt<=cnt+1.
  - After W steps (cnt==W-1 on the step edge), go FIN.
  - Fixed latency: no early exit on mb==0.
- FIN:
  - acc_mode=1: Result<=(Result+zero-extended prod) mod 2^ACC_W; Ovf<=Ovf | carry-out.
  - acc_mode=0: Result<=zero-extended prod; Ovf unchanged.
  - Done<=1; go IDLE.
- Timing: Start accepted at edge k gives RUN at edges k+1..k+W and FIN at k+W. Result and Done both update at edge k+W+1, and Done falls at k+W+2.
- Busy is registered: 1 from edge k through edge k+W+1; it is 0 in the cycle Done is high.
- A Start held high while Done=1 is accepted at that edge, giving back-to-back operations with one bubble.
- Start, Accum, Clear, A and B are ignored while Busy=1. Changing A/B mid-operation does not affect the result.
- Result holds its value except at FIN or on Clear; it is never X after reset.
- Product width is 2W bits and never overflows. Only accumulate mode can set Ovf.
- Start, Clear and Accum are assumed synchronous to Clock (debounced upstream).

Test Plan:
- W=4, ACC_W=16: reset, Start with A=3, B=5, Accum=0 → Busy high 5 cycles, Done pulse at edge k+5, Result=15, Ovf=0.
- A=15, B=15, Accum=0, then Start again with A=15, B=15, Accum=1 → Result=225, then 450; Done pulses exactly twice; Ovf=0.
- ACC_W=8: two accumulates of 15×15 from Result=0 → 225, then 194 (450 mod 256); Ovf=1 and stays 1 after a further Accum=0 op (Result=225). Clear in IDLE → Result=0, Ovf=0.
- Start with A=0, B=9, and with A=7, B=0 → Result=0 in both cases; latency is still W+1 edges.
- Mid-RUN: change A/B and pulse Start → ignored; result matches the originally captured operands. Clear and Start together in IDLE → Result=0, no operation started, Busy stays 0.
- Assert Resetn=0 during RUN (cycle 2) → Busy=0, Result=0 immediately and asynchronously; no Done; the next Start works normally.

Source files
------------

// File: rtl/mult_seq_ctrl_if.sv
// Operand/handshake bundle for mult_seq_ctrl.
//   master : drives Start, Accum, Clear, A, B; observes Busy, Done, Result, Ovf
//   slave  : the multiply controller side
interface mult_seq_ctrl_if #(
    parameter int W     = 4,
    parameter int ACC_W = 16
);
    logic             Start;
    logic             Accum;
    logic             Clear;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             Busy;
    logic             Done;
    logic [ACC_W-1:0] Result;
    logic             Ovf;

    modport master (
        output Start, Accum, Clear, A, B,
        input  Busy, Done, Result, Ovf
    );

    modport slave (
        input  Start, Accum, Clear, A, B,
        output Busy, Done, Result, Ovf
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiply/accumulate controller.
// A W-step multiply is started from IDLE by Start; the product either
// overwrites Result or is added to it (Accum), with a sticky carry-out flag.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : slave side of mult_seq_ctrl_if
//            Start/Accum/Clear/A/B in, Busy/Done/Result/Ovf out
module mult_seq_ctrl #(
    parameter int W     = 4,
    parameter int ACC_W = 16
) (
    input  logic           Clock,
    input  logic           Resetn,
    mult_seq_ctrl_if.slave bus
);
    localparam int PW = 2 * W;
    localparam int SW = ACC_W + 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    ma;
    logic [W-1:0]     mb;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    cnt;
    logic             acc_mode;
    logic [ACC_W-1:0] result_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             clr;
    logic             step;
    logic             fin;
    logic [SW-1:0]    sum;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        clr      = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                // Clear wins; a Start in the same cycle is dropped.
                if (bus.Clear) begin
                    clr = 1'b1;
                end else if (bus.Start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(W - 1)) state_nx = FIN;
            end
            FIN: begin
                fin      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One extra bit catches the accumulate carry-out.
    assign sum = {1'b0, result_q} + SW'(prod);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ma       <= '0;
            mb       <= '0;
            prod     <= '0;
            cnt      <= '0;
            acc_mode <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin;
            if (clr) begin
                result_q <= '0;
                ovf_q    <= 1'b0;
            end
            if (accept) begin
                ma       <= PW'(bus.A);
                mb       <= bus.B;
                acc_mode <= bus.Accum;
                prod     <= '0;
                cnt      <= '0;
                busy_q   <= 1'b1;
            end
            if (step) begin
                if (mb[0]) prod <= prod + ma;
                ma  <= ma << 1;
                mb  <= mb >> 1;
                cnt <= cnt + CW'(1);
            end
            if (fin) begin
                busy_q <= 1'b0;
                if (acc_mode) begin
                    result_q <= sum[ACC_W-1:0];
                    ovf_q    <= ovf_q | sum[ACC_W];
                end else begin
                    result_q <= ACC_W'(prod);
                end
            end
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.Ovf    = ovf_q;
endmodule
